// File: rtl/wb_write_arbiter_pkg.sv
// Shared types and constants for the register-file write arbiter.
// Optional forwarding support elsewhere is enabled with the WB_FWD_EN macro.
package wb_write_arbiter_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  // Register x0 is hard-wired to zero and is never written.
  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

  // One pending register-file write as seen at the queue head.
  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_write_arbiter_if.sv
// Bundle of producer, register-file and decode-probe signals of the write
// arbiter. Forwarding signals exist only when WB_FWD_EN is defined.
interface wb_write_arbiter_if #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = wb_write_arbiter_pkg::ADDR_W,
  parameter int DATA_W = wb_write_arbiter_pkg::DATA_W
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              alu_valid;
  logic [ADDR_W-1:0] alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;

  logic              mem_valid;
  logic [ADDR_W-1:0] mem_rd;
  logic [DATA_W-1:0] mem_data;
  logic              mem_ready;

  logic [ADDR_W-1:0] rd;
  logic [DATA_W-1:0] rd_data;
  logic              reg_write;

  logic [ADDR_W-1:0] query_reg;
  logic              query_pending;
  logic [CNT_W-1:0]  count;

`ifdef WB_FWD_EN
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;
`endif

  // Producers, register file and decode probe.
  modport master (
    output alu_valid, alu_rd, alu_data,
    output mem_valid, mem_rd, mem_data,
    output query_reg,
    input  alu_ready, mem_ready,
    input  rd, rd_data, reg_write,
    input  query_pending, count
`ifdef WB_FWD_EN
    , input fwd_hit, fwd_data
`endif
  );

  // The arbiter itself.
  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  mem_valid, mem_rd, mem_data,
    input  query_reg,
    output alu_ready, mem_ready,
    output rd, rd_data, reg_write,
    output query_pending, count
`ifdef WB_FWD_EN
    , output fwd_hit, fwd_data
`endif
  );

endinterface

// File: rtl/wb_write_arbiter_match_search.sv
// Associative search of the write queue for a register index. Always yields
// the hit flag; with WB_FWD_EN it also returns the data of the youngest match.
module wb_match_search
  import wb_write_arbiter_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = wb_write_arbiter_pkg::ADDR_W
`ifdef WB_FWD_EN
  , parameter int DATA_W = wb_write_arbiter_pkg::DATA_W
`endif
) (
  input  logic [DEPTH-1:0]             ent_valid,
  input  logic [DEPTH-1:0][ADDR_W-1:0] ent_rd,
`ifdef WB_FWD_EN
  input  logic [DEPTH-1:0][DATA_W-1:0] ent_data,
  input  logic [$clog2(DEPTH)-1:0]     head_ptr,
  output logic [DATA_W-1:0]            hit_data,
`endif
  input  logic [ADDR_W-1:0]            key,
  output logic                         hit
);

  logic [DEPTH-1:0] match;

  // Per-entry compare; x0 never counts as pending.
  always_comb begin
    match = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match[i] = ent_valid[i] && (ent_rd[i] == key);
    end
    hit = (key != ADDR_W'(REG_ZERO)) && (|match);
  end

`ifdef WB_FWD_EN
  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] idx;

  // Walk oldest to youngest from the head so the youngest match wins.
  always_comb begin
    hit_data = '0;
    idx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_ptr + PTR_W'(k);
      if (match[idx]) begin
        hit_data = ent_data[idx];
      end
    end
  end
`endif

endmodule

// File: rtl/wb_write_arbiter.sv
// In-order write queue merging ALU and load results into the single
// register-file write port, draining one write per cycle and reporting
// pending destinations to decode. Define WB_FWD_EN to add the
// fwd_hit/fwd_data forwarding outputs.
module wb_write_arbiter
  import wb_write_arbiter_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = wb_write_arbiter_pkg::DATA_W,
  parameter int ADDR_W = wb_write_arbiter_pkg::ADDR_W
) (
  input logic               clk,
  input logic               rst,
  wb_write_arbiter_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO_C   = CNT_W'(2);

  // Queue control state (reset) and payload storage (not reset).
  logic [PTR_W-1:0]             wr_ptr_q;
  logic [PTR_W-1:0]             rd_ptr_q;
  logic [CNT_W-1:0]             count_q;
  logic [DEPTH-1:0]             vld_q;
  logic [DEPTH-1:0][ADDR_W-1:0] rd_q;
  logic [DEPTH-1:0][DATA_W-1:0] data_q;

  logic [CNT_W-1:0] free_slots;
  logic             mem_ready;
  logic             alu_ready;
  logic             mem_enq;
  logic             alu_enq;
  logic             deq;
  logic [PTR_W-1:0] mem_slot;
  logic [PTR_W-1:0] alu_slot;
  logic [CNT_W-1:0] enq_cnt;
  logic             query_hit;
  wb_entry_t        head;

  // Readiness depends only on occupancy; loads keep one slot of headroom
  // over ALU results so they can always get in.
  always_comb begin
    free_slots = DEPTH_C - count_q;
    mem_ready  = free_slots >= ONE_C;
    alu_ready  = free_slots >= TWO_C;
  end

  // Accepted results for x0 finish the handshake but are dropped; the load
  // result takes the lower slot when both arrive together.
  always_comb begin
    mem_enq  = bus.mem_valid && mem_ready && (bus.mem_rd != ADDR_W'(REG_ZERO));
    alu_enq  = bus.alu_valid && alu_ready && (bus.alu_rd != ADDR_W'(REG_ZERO));
    deq      = count_q != '0;
    mem_slot = wr_ptr_q;
    alu_slot = wr_ptr_q + PTR_W'(mem_enq);
    enq_cnt  = CNT_W'(mem_enq) + CNT_W'(alu_enq);
  end

  // Pointers, occupancy and entry-valid bits; reset drops every queued write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      vld_q    <= '0;
    end else begin
      if (deq) begin
        vld_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q        <= rd_ptr_q + PTR_W'(1);
      end
      if (mem_enq) begin
        vld_q[mem_slot] <= 1'b1;
      end
      if (alu_enq) begin
        vld_q[alu_slot] <= 1'b1;
      end
      wr_ptr_q <= wr_ptr_q + enq_cnt[PTR_W-1:0];
      count_q  <= count_q + enq_cnt - CNT_W'(deq);
    end
  end

  // Capture destination and data of accepted results into their slots.
  always_ff @(posedge clk) begin
    if (mem_enq) begin
      rd_q[mem_slot]   <= bus.mem_rd;
      data_q[mem_slot] <= bus.mem_data;
    end
    if (alu_enq) begin
      rd_q[alu_slot]   <= bus.alu_rd;
      data_q[alu_slot] <= bus.alu_data;
    end
  end

  // Head entry drives the register-file write port; zeros when empty.
  always_comb begin
    head.valid = vld_q[rd_ptr_q];
    head.rd    = rd_q[rd_ptr_q];
    head.data  = data_q[rd_ptr_q];
  end

  assign bus.reg_write = deq;
  assign bus.rd        = head.valid ? head.rd : '0;
  assign bus.rd_data   = head.valid ? head.data : '0;
  assign bus.mem_ready = mem_ready;
  assign bus.alu_ready = alu_ready;
  assign bus.count     = count_q;

  wb_match_search #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
`ifdef WB_FWD_EN
    , .DATA_W (DATA_W)
`endif
  ) u_match (
    .ent_valid (vld_q),
    .ent_rd    (rd_q),
`ifdef WB_FWD_EN
    .ent_data  (data_q),
    .head_ptr  (rd_ptr_q),
    .hit_data  (bus.fwd_data),
`endif
    .key       (bus.query_reg),
    .hit       (query_hit)
  );

  assign bus.query_pending = query_hit;
`ifdef WB_FWD_EN
  assign bus.fwd_hit = query_hit;
`endif

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) count_q <= DEPTH_C);

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed bench for wb_write_arbiter (DEPTH=4). Forwarding outputs are
// checked only when WB_FWD_EN is defined.
module tb_wb_write_arbiter;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;

  wb_write_arbiter_if #(.DEPTH(DEPTH)) bus ();

  wb_write_arbiter #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.alu_valid = 1'b0;
    bus.alu_rd    = '0;
    bus.alu_data  = '0;
    bus.mem_valid = 1'b0;
    bus.mem_rd    = '0;
    bus.mem_data  = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int exp_cnt [10] = '{2, 3, 3, 3, 3, 3, 2, 2, 1, 0};
  int exp_rd  [10] = '{10, 20, 11, 21, 12, 13, 14, 15, 22, 0};
  int exp_dat [10] = '{'h100, 'h200, 'h101, 'h201, 'h102, 'h103, 'h104, 'h105, 'h202, 0};
  int exp_ar  [10] = '{1, 0, 0, 0, 0, 0, 1, 1, 1, 1};

  initial begin
    rst = 1'b1;
    idle_inputs();
    bus.query_reg = '0;
    step();
    step();

    // Reset state
    check("rst_count", bus.count, 0);
    check("rst_reg_write", bus.reg_write, 0);
    check("rst_rd", bus.rd, 0);
    check("rst_rd_data", bus.rd_data, 0);
    check("rst_query_pending", bus.query_pending, 0);
    rst = 1'b0;
    #1;
    check("idle_mem_ready", bus.mem_ready, 1);
    check("idle_alu_ready", bus.alu_ready, 1);

    // Single ALU write
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd5;
    bus.alu_data  = 32'h0000_00AA;
    step();
    idle_inputs();
    check("single_reg_write", bus.reg_write, 1);
    check("single_rd", bus.rd, 5);
    check("single_rd_data", bus.rd_data, 'hAA);
    check("single_count", bus.count, 1);
    step();
    check("single_drained_count", bus.count, 0);
    check("single_drained_reg_write", bus.reg_write, 0);
    check("single_drained_rd", bus.rd, 0);

    // Dual same-cycle accept: load first, then ALU
    bus.mem_valid = 1'b1;
    bus.mem_rd    = 5'd3;
    bus.mem_data  = 32'h11;
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd4;
    bus.alu_data  = 32'h22;
    step();
    idle_inputs();
    check("dual_count", bus.count, 2);
    check("dual_first_rd", bus.rd, 3);
    check("dual_first_data", bus.rd_data, 'h11);
    step();
    check("dual_second_rd", bus.rd, 4);
    check("dual_second_data", bus.rd_data, 'h22);
    check("dual_second_count", bus.count, 1);
    step();
    check("dual_empty_reg_write", bus.reg_write, 0);

    // x0 destination is accepted and discarded
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd0;
    bus.alu_data  = 32'hFFFF_FFFF;
    #1;
    check("x0_alu_ready", bus.alu_ready, 1);
    step();
    idle_inputs();
    check("x0_count", bus.count, 0);
    check("x0_reg_write", bus.reg_write, 0);

    // Backpressure: both producers busy, ordering and readiness per cycle
    for (int k = 1; k <= 10; k++) begin
      int ai;
      bus.mem_valid = (k <= 6);
      bus.mem_rd    = 5'(10 + k - 1);
      bus.mem_data  = 32'(32'h100 + k - 1);
      ai = (k == 1) ? 0 : ((k == 2) ? 1 : 2);
      bus.alu_valid = (k <= 8);
      bus.alu_rd    = 5'(20 + ai);
      bus.alu_data  = 32'(32'h200 + ai);
      step();
      check($sformatf("bp_count_%0d", k), bus.count, 64'(exp_cnt[k-1]));
      check($sformatf("bp_rd_%0d", k), bus.rd, 64'(exp_rd[k-1]));
      check($sformatf("bp_data_%0d", k), bus.rd_data, 64'(exp_dat[k-1]));
      check($sformatf("bp_alu_ready_%0d", k), bus.alu_ready, 64'(exp_ar[k-1]));
      check($sformatf("bp_mem_ready_%0d", k), bus.mem_ready, 1);
    end
    idle_inputs();
    check("bp_final_reg_write", bus.reg_write, 0);

    // Hazard probe with two writes to the same register
    bus.query_reg = 5'd7;
    #1;
    check("hz_empty_pending", bus.query_pending, 0);
    bus.mem_valid = 1'b1;
    bus.mem_rd    = 5'd7;
    bus.mem_data  = 32'h10;
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd7;
    bus.alu_data  = 32'h20;
    step();
    idle_inputs();
    check("hz_pending_both", bus.query_pending, 1);
    check("hz_head_data", bus.rd_data, 'h10);
`ifdef WB_FWD_EN
    check("hz_fwd_hit", bus.fwd_hit, 1);
    check("hz_fwd_data_youngest", bus.fwd_data, 'h20);
`endif
    bus.query_reg = 5'd9;
    #1;
    check("hz_other_reg", bus.query_pending, 0);
    bus.query_reg = 5'd7;
    step();
    check("hz_pending_head_only", bus.query_pending, 1);
    check("hz_second_data", bus.rd_data, 'h20);
`ifdef WB_FWD_EN
    check("hz_fwd_data_last", bus.fwd_data, 'h20);
`endif
    step();
    check("hz_drained_pending", bus.query_pending, 0);
    bus.query_reg = '0;

    // Reset during traffic with three writes queued
    bus.mem_valid = 1'b1;
    bus.mem_rd    = 5'd1;
    bus.mem_data  = 32'hA1;
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd2;
    bus.alu_data  = 32'hA2;
    step();
    bus.mem_rd    = 5'd3;
    bus.mem_data  = 32'hA3;
    bus.alu_rd    = 5'd6;
    bus.alu_data  = 32'hA6;
    step();
    idle_inputs();
    check("mid_count_before_rst", bus.count, 3);
    check("mid_head_rd", bus.rd, 2);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_count", bus.count, 0);
    check("mid_rst_reg_write", bus.reg_write, 0);
    check("mid_rst_rd", bus.rd, 0);
    check("mid_rst_rd_data", bus.rd_data, 0);
    step();
    rst = 1'b0;
    step();
    check("post_rst_count", bus.count, 0);
    check("post_rst_reg_write", bus.reg_write, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
